// File: rtl/stream_upsize_buf.sv
// Narrow-to-wide stream upsizer: packs T_DATA_RATIO words into one beat behind a 2-entry FIFO.
// Define STREAM_UPSIZE_TIMEOUT_EN to flush partial beats after TIMEOUT_CYCLES idle cycles.
module stream_upsize_buf #(
  parameter int T_DATA_WIDTH   = 4,
  parameter int T_DATA_RATIO   = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [T_DATA_WIDTH-1:0] s_data_i,
  input  logic                    s_last_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o [T_DATA_RATIO],
  output logic [T_DATA_RATIO-1:0] m_keep_o,
  output logic                    m_last_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i
);

  localparam int W    = T_DATA_WIDTH;
  localparam int R    = T_DATA_RATIO;
  localparam int DW   = W * R;
  localparam int IDXW = (R > 1) ? $clog2(R) : 1;
  localparam logic [IDXW-1:0] IDX_MAX = IDXW'(R - 1);

  if ((T_DATA_WIDTH < 1) || (T_DATA_RATIO < 2) || (TIMEOUT_CYCLES < 1)) begin : g_param_check
    $error("stream_upsize_buf: illegal parameter value");
  end

  logic [IDXW-1:0] idx_r;
  logic [DW-1:0]   lane_r;
  logic [R-1:0]    keep_r;

  logic [1:0]      count_r;
  logic [1:0]      count_next_s;
  logic            ready_r;
  logic [DW-1:0]   ent0_data_r;
  logic [R-1:0]    ent0_keep_r;
  logic            ent0_last_r;
  logic [DW-1:0]   ent1_data_r;
  logic [R-1:0]    ent1_keep_r;
  logic            ent1_last_r;

  logic            accept_s;
  logic            pop_s;
  logic            complete_s;
  logic            flush_s;
  logic            push_s;
  logic [DW-1:0]   beat_data_s;
  logic [R-1:0]    beat_keep_s;
  logic            beat_last_s;

  // Ready depends only on registered occupancy; reset forces it low combinationally.
  assign s_ready_o = !rst && ready_r;

  // Handshake qualifiers and beat-completion decode.
  always_comb begin
    accept_s   = s_valid_i && s_ready_o;
    pop_s      = (count_r != 2'd0) && m_ready_i;
    complete_s = accept_s && ((idx_r == IDX_MAX) || s_last_i);
    push_s     = complete_s || flush_s;
  end

`ifdef STREAM_UPSIZE_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] idle_r;

  // Flush fires on the TIMEOUT_CYCLES-th consecutive idle cycle, and only if the FIFO has room.
  always_comb begin
    flush_s = (idx_r != {IDXW{1'b0}}) && !accept_s && (idle_r == TMO_LAST) && (count_r != 2'd2);
  end

  // Idle counter: saturates at the threshold while the FIFO is full.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_r <= {TW{1'b0}};
    end else if (accept_s || flush_s) begin
      idle_r <= {TW{1'b0}};
    end else if ((idx_r != {IDXW{1'b0}}) && (idle_r != TMO_LAST)) begin
      idle_r <= idle_r + TW'(1);
    end
  end
`else
  assign flush_s = 1'b0;
`endif

  // Beat as it would be pushed this cycle: the incoming word merged into its lane.
  always_comb begin
    beat_data_s = lane_r;
    beat_keep_s = keep_r;
    beat_last_s = 1'b0;
    if (accept_s) begin
      for (int l = 0; l < R; l++) begin
        if (idx_r == IDXW'(l)) begin
          beat_data_s[l*W +: W] = s_data_i;
          beat_keep_s[l]        = 1'b1;
        end else begin
          beat_data_s[l*W +: W] = lane_r[l*W +: W];
          beat_keep_s[l]        = keep_r[l];
        end
      end
      beat_last_s = s_last_i;
    end else begin
      beat_last_s = 1'b0;
    end
  end

  // Assembly register; cleared after every push so unwritten lanes stay zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r  <= {IDXW{1'b0}};
      lane_r <= {DW{1'b0}};
      keep_r <= {R{1'b0}};
    end else if (push_s) begin
      idx_r  <= {IDXW{1'b0}};
      lane_r <= {DW{1'b0}};
      keep_r <= {R{1'b0}};
    end else if (accept_s) begin
      idx_r  <= idx_r + IDXW'(1);
      lane_r <= beat_data_s;
      keep_r <= beat_keep_s;
    end
  end

  // Next FIFO occupancy.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + 2'd1;
      2'b01:   count_next_s = count_r - 2'd1;
      default: count_next_s = count_r;
    endcase
  end

  // Two-entry FIFO; entry 0 is the head and drives the outputs directly from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r     <= 2'd0;
      ready_r     <= 1'b1;
      ent0_data_r <= {DW{1'b0}};
      ent0_keep_r <= {R{1'b0}};
      ent0_last_r <= 1'b0;
      ent1_data_r <= {DW{1'b0}};
      ent1_keep_r <= {R{1'b0}};
      ent1_last_r <= 1'b0;
    end else begin
      count_r <= count_next_s;
      ready_r <= (count_next_s != 2'd2);
      case (count_r)
        2'd0: begin
          if (push_s) begin
            ent0_data_r <= beat_data_s;
            ent0_keep_r <= beat_keep_s;
            ent0_last_r <= beat_last_s;
          end
        end
        2'd1: begin
          if (push_s && pop_s) begin
            ent0_data_r <= beat_data_s;
            ent0_keep_r <= beat_keep_s;
            ent0_last_r <= beat_last_s;
          end else if (push_s) begin
            ent1_data_r <= beat_data_s;
            ent1_keep_r <= beat_keep_s;
            ent1_last_r <= beat_last_s;
          end else if (pop_s) begin
            ent0_data_r <= {DW{1'b0}};
            ent0_keep_r <= {R{1'b0}};
            ent0_last_r <= 1'b0;
          end
        end
        2'd2: begin
          if (pop_s) begin
            ent0_data_r <= ent1_data_r;
            ent0_keep_r <= ent1_keep_r;
            ent0_last_r <= ent1_last_r;
            ent1_data_r <= {DW{1'b0}};
            ent1_keep_r <= {R{1'b0}};
            ent1_last_r <= 1'b0;
          end
        end
        default: begin
          count_r <= 2'd0;
        end
      endcase
    end
  end

  // Output lanes unpacked from the FIFO head.
  always_comb begin
    for (int l = 0; l < R; l++) begin
      m_data_o[l] = ent0_data_r[l*W +: W];
    end
    m_keep_o  = ent0_keep_r;
    m_last_o  = ent0_last_r;
    m_valid_o = (count_r != 2'd0);
  end

endmodule

// File: tb/tb_stream_upsize_buf.sv
// Directed bench for stream_upsize_buf with a queue-based reference model checked every cycle.
module tb_stream_upsize_buf;
  localparam int W   = 4;
  localparam int R   = 2;
  localparam int TMO = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] s_data_i;
  logic         s_last_i;
  logic         s_valid_i;
  logic         s_ready_o;
  logic [W-1:0] m_data_o [R];
  logic [R-1:0] m_keep_o;
  logic         m_last_o;
  logic         m_valid_o;
  logic         m_ready_i;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [R*W-1:0] d;
    logic [R-1:0]   keep;
    logic           last;
  } beat_t;

  beat_t        exp_q[$];
  beat_t        got_q[$];
  logic [W-1:0] asm_q[$];
  int           idle_cnt    = 0;
  int           rdy_mode    = 0;
  bit           watch_ready = 1'b0;
  int           drops       = 0;

  always #5 clk = ~clk;

  stream_upsize_buf #(.T_DATA_WIDTH(W), .T_DATA_RATIO(R), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .s_data_i(s_data_i), .s_last_i(s_last_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .m_data_o(m_data_o), .m_keep_o(m_keep_o), .m_last_o(m_last_o),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Beat from whatever words are pending: filled lanes in order, zero elsewhere.
  function automatic beat_t mk(input logic last);
    beat_t b;
    b.d    = '0;
    b.keep = '0;
    for (int l = 0; l < asm_q.size(); l++) begin
      b.d[l*W +: W] = asm_q[l];
      b.keep[l]     = 1'b1;
    end
    b.last = last;
    return b;
  endfunction

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_ready_i = 1'b1;
      1:       m_ready_i = 1'b0;
      default: m_ready_i = !m_ready_i;
    endcase
  end

  // Reference model and per-cycle compare.
  always @(negedge clk) begin
    beat_t b;
    beat_t h;
    int    sz;
    bit    acc;
    if (rst) begin
      chk("ready_in_reset", s_ready_o, 0);
      exp_q.delete();
      asm_q.delete();
      idle_cnt = 0;
    end else begin
      sz = exp_q.size();
      chk("m_valid", m_valid_o, sz != 0);
      chk("s_ready", s_ready_o, sz < 2);
      if (watch_ready && !s_ready_o) drops++;
      if (m_valid_o && sz != 0) begin
        h = exp_q[0];
        for (int l = 0; l < R; l++) chk("m_data", m_data_o[l], h.d[l*W +: W]);
        chk("m_keep", m_keep_o, h.keep);
        chk("m_last", m_last_o, h.last);
        if (m_ready_i) begin
          for (int l = 0; l < R; l++) b.d[l*W +: W] = m_data_o[l];
          b.keep = m_keep_o;
          b.last = m_last_o;
          got_q.push_back(b);
          void'(exp_q.pop_front());
        end
      end
      acc = s_valid_i && s_ready_o;
      if (acc) begin
        asm_q.push_back(s_data_i);
        idle_cnt = 0;
        if (asm_q.size() == R || s_last_i) begin
          exp_q.push_back(mk(s_last_i));
          asm_q.delete();
        end
      end
`ifdef STREAM_UPSIZE_TIMEOUT_EN
      else if (asm_q.size() != 0) begin
        idle_cnt++;
        if (idle_cnt >= TMO) begin
          if (sz < 2) begin
            exp_q.push_back(mk(1'b0));
            asm_q.delete();
            idle_cnt = 0;
          end else begin
            idle_cnt = TMO;
          end
        end
      end
`endif
    end
  end

  task automatic send(input logic [W-1:0] d, input logic last);
    bit done = 1'b0;
    s_valid_i = 1'b1;
    s_data_i  = d;
    s_last_i  = last;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      if (s_ready_o) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!done) chk("send_accept", 0, 1);
  endtask

  task automatic idle(input int n);
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_beat(input string nm, input int i, input logic [W-1:0] d0, input logic [W-1:0] d1,
                          input logic [R-1:0] keep, input logic last);
    if (got_q.size() > i) begin
      chk({nm, "_lane0"}, got_q[i].d[W-1:0], d0);
      chk({nm, "_lane1"}, got_q[i].d[2*W-1:W], d1);
      chk({nm, "_keep"}, got_q[i].keep, keep);
      chk({nm, "_last"}, got_q[i].last, last);
    end else begin
      chk({nm, "_missing"}, got_q.size(), i + 1);
    end
  endtask

  initial begin
    int lat;
    bit seen;
    rst = 1'b1;
    s_valid_i = 1'b0;
    s_data_i  = '0;
    s_last_i  = 1'b0;
    m_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_s_ready", s_ready_o, 1);
    chk("rst_m_valid", m_valid_o, 0);
    chk("rst_m_keep", m_keep_o, 0);
    chk("rst_m_last", m_last_o, 0);
    chk("rst_lane0", m_data_o[0], 0);
    chk("rst_lane1", m_data_o[1], 0);
    @(posedge clk);
    #1;

    // 0,1,2(last): a full beat then a partial last beat
    got_q.delete();
    send(4'h0, 1'b0);
    send(4'h1, 1'b0);
    send(4'h2, 1'b1);
    idle(6);
    chk("t1_count", got_q.size(), 2);
    chk_beat("t1_b0", 0, 4'h0, 4'h1, 2'b11, 1'b0);
    chk_beat("t1_b1", 1, 4'h2, 4'h0, 2'b01, 1'b1);

    // A, B(last): last on the top lane, valid one cycle after acceptance
    got_q.delete();
    send(4'hA, 1'b0);
    send(4'hB, 1'b1);
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
    @(negedge clk);
    chk("t2_valid", m_valid_o, 1);
    chk("t2_lane0", m_data_o[0], 4'hA);
    chk("t2_lane1", m_data_o[1], 4'hB);
    chk("t2_keep", m_keep_o, 2'b11);
    chk("t2_last", m_last_o, 1);
    @(posedge clk);
    #1;
    idle(4);

    // Output blocked: two beats fill the FIFO, then release
    got_q.delete();
    rdy_mode = 1;
    send(4'h0, 1'b0);
    send(4'h1, 1'b0);
    send(4'h2, 1'b0);
    send(4'h3, 1'b0);
    @(negedge clk);
    chk("t3_ready_low", s_ready_o, 0);
    @(posedge clk);
    #1;
    fork
      begin
        send(4'h4, 1'b0);
        send(4'h5, 1'b0);
      end
      begin
        repeat (5) @(posedge clk);
        rdy_mode = 0;
      end
    join
    idle(10);
    chk("t3_count", got_q.size(), 3);
    chk_beat("t3_b0", 0, 4'h0, 4'h1, 2'b11, 1'b0);
    chk_beat("t3_b1", 1, 4'h2, 4'h3, 2'b11, 1'b0);
    chk_beat("t3_b2", 2, 4'h4, 4'h5, 2'b11, 1'b0);

    // Toggling m_ready_i with continuous input
    got_q.delete();
    rdy_mode    = 2;
    drops       = 0;
    watch_ready = 1'b1;
    for (int i = 0; i < 20; i++) send(4'(i), 1'b0);
    watch_ready = 1'b0;
    rdy_mode    = 0;
    idle(10);
    chk("t4_ready_drops", drops, 0);
    chk("t4_count", got_q.size(), 10);
    chk_beat("t4_b0", 0, 4'h0, 4'h1, 2'b11, 1'b0);
    chk_beat("t4_b9", 9, 4'h2, 4'h3, 2'b11, 1'b0);

    // Reset with a half-filled beat discards it
    got_q.delete();
    send(4'h7, 1'b0);
    s_valid_i = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_valid_after_rst", m_valid_o, 0);
    @(posedge clk);
    #1;
    send(4'h8, 1'b0);
    send(4'h9, 1'b0);
    idle(6);
    chk("t5_count", got_q.size(), 1);
    chk_beat("t5_b0", 0, 4'h8, 4'h9, 2'b11, 1'b0);

    // Single word followed by silence
    got_q.delete();
    send(4'h3, 1'b0);
    s_valid_i = 1'b0;
    lat  = 0;
    seen = 1'b0;
    for (int k = 1; k <= 100 && !seen; k++) begin
      @(negedge clk);
      if (m_valid_o) begin
        seen = 1'b1;
        lat  = k;
      end
    end
`ifdef STREAM_UPSIZE_TIMEOUT_EN
    chk("t6_flush_seen", seen, 1);
    chk("t6_latency", lat, TMO + 1);
    chk("t6_lane0", m_data_o[0], 4'h3);
    chk("t6_lane1", m_data_o[1], 4'h0);
    chk("t6_keep", m_keep_o, 2'b01);
    chk("t6_last", m_last_o, 0);
`else
    chk("t6_no_flush", seen, 0);
    chk("t6_valid", m_valid_o, 0);
`endif
    @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/stream_upsize_buf.md
# stream_upsize_buf

Parametrised narrow-to-wide stream upsizer with a two-entry output buffer. Packs T_DATA_RATIO consecutive T_DATA_WIDTH words into one wide beat, flushes partial beats on `s_last_i` with a contiguous `m_keep_o` mask, and keeps `s_ready_o` high across single-cycle output stalls. It sits between narrow producers and the wide interconnect fabric.

## Interface
- `T_DATA_WIDTH`, 4: width of one narrow word; must be ≥1.
- `T_DATA_RATIO`, 2: narrow words per wide beat; must be ≥2.
- `TIMEOUT_CYCLES`, 16: idle-flush threshold; must be ≥1. Used only with `STREAM_UPSIZE_TIMEOUT_EN`.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `s_data_i`  in  T_DATA_WIDTH  narrow input word.
- `s_last_i`  in  1  marks the final word of a packet.
- `s_valid_i`  in  1  input word valid.
- `s_ready_o`  out  1  input ready.
- `m_data_o`  out  T_DATA_WIDTH × [T_DATA_RATIO] (unpacked)  output lanes; lane 0 carries the first word.
- `m_keep_o`  out  T_DATA_RATIO  per-lane valid mask.
- `m_last_o`  out  1  beat ends a packet.
- `m_valid_o`  out  1  output beat valid.
- `m_ready_i`  in  1  output ready.

## Operation
- Input handshake: a word is accepted on any edge where `s_valid_i && s_ready_o`.
- Output handshake: a beat is popped on any edge where `m_valid_o && m_ready_i`.
- Assembly register: holds a lane index `idx` (0..RATIO-1), lane data, and keep bits.
  - Each accepted word is written to lane `idx` and sets `keep[idx]`.
- Beat completion: on an accepted word with `idx==RATIO-1` or `s_last_i==1`.
  - The assembled beat is pushed into the output FIFO on the same edge.
  - `last` is the `s_last_i` of that word.
  - `idx` and keep clear to 0.
- Unwritten lanes output data 0 and keep 0. The keep mask is always contiguous from lane 0.
- A last word on lane RATIO-1 produces keep all-ones with `last=1`.
- Output FIFO: 2 entries, 2-bit count 0..2. `m_valid_o` = count≠0; the head drives `m_data_o`, `m_keep_o`, and `m_last_o`.
- `s_ready_o` = !rst && count<2. It is purely registered-state based, with no combinational path from `m_ready_i`. It is held low at count==2 even mid-assembly.
- Simultaneous push and pop: count is unchanged and the FIFO order is preserved.
- Push at count==1 with no pop: count becomes 2 and `s_ready_o` drops on the next cycle.
- Output stability: while `m_valid_o && !m_ready_i`, all m_* outputs hold stable.
- Reset mid-operation: the partial beat and FIFO contents are discarded, with no flush.

## Timing
- Reset values:
  - `s_ready_o`=0 while `rst` is high, and 1 on the first cycle after `rst` deasserts.
  - `m_valid_o`=0, `m_last_o`=0, `m_keep_o`=0, and all `m_data_o` lanes =0.
- Latency: a beat is valid on `m_valid_o` in the cycle after the edge that accepted its completing word.
- Throughput:
  - Input accepts 1 word/cycle sustained while `m_ready_i`=1.
  - Output issues 1 beat per RATIO cycles, or earlier on last.
- Stall tolerance: `m_ready_i` low for one cycle never deasserts `s_ready_o`. Two consecutive unpopped beats fill the FIFO and deassert `s_ready_o`.

## Configuration
- Macro: `STREAM_UPSIZE_TIMEOUT_EN`.
- Defined: an idle counter counts cycles with idx>0 and no accepted word.
  - It resets to 0 on every accepted word and on every flush.
  - When it reaches `TIMEOUT_CYCLES` and count<2, the partial beat is pushed with its keep and last=0, and idx clears.
  - If the FIFO is full, the counter saturates and the flush waits for space.
  - An accepted word on the expiry cycle wins; no flush occurs.
- Undefined: partial beats are held indefinitely until filled or ended by `s_last_i`. The counter logic is absent.

## Test plan
- W=4, R=2, `m_ready_i`=1, continuous words 0,1,2(last) -> beat lanes {0,1} keep 2'b11 last 0, then lanes {2,0} keep 2'b01 last 1.
- Words A, B(last) -> lanes {A,B}, keep 2'b11, last 1, valid one cycle after B is accepted.
- `m_ready_i`=0, stream 0..5 -> `s_ready_o` drops after 2 beats are buffered; release -> beats {0,1},{2,3},{4,5} in order, no loss or duplication.
- `m_ready_i` toggling 1/0 every cycle with continuous input -> `s_ready_o` never deasserts; `m_data_o` stable while stalled.
- Assert `rst` after word 7 is accepted (idx=1) -> next cycle `m_valid_o`=0; words 8,9 -> beat {8,9} keep 2'b11.
- With `STREAM_UPSIZE_TIMEOUT_EN`, TIMEOUT=16: single word 3 then idle -> beat lanes {3,0} keep 2'b01 last 0 after 16 idle cycles. Without the macro -> no beat within 100 cycles.
